sha256_message_schedule: RTL
============================

# sha256_message_schedule

Expands one 512-bit preprocessed SHA-256 block into the 64-word message schedule W[0..63] and streams one 32-bit word per accepted cycle. Sits directly downstream of the preprocessor: it captures that stage's 512-bit block when told to begin, then feeds the compression-round stage through a valid/advance handshake. A 16-word sliding window is used, so no 64-word storage is needed.

## Interface
- NUM_WORDS, 64, number of schedule words emitted per block (fixed by SHA-256; not for override)
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  asynchronous active-low reset
- processedMsg  input  512  preprocessed block; bits [511:480] are W[0], [31:0] are W[15]; must be stable during the LOAD cycle
- beginSchedule  input  1  start request; sampled only in IDLE
- advance  input  1  consumer accepts the current word this cycle
- w_out  output  32  current schedule word W[w_index]
- w_index  output  6  index t of w_out, 0..63
- w_valid  output  1  w_out/w_index are valid (high only in EMIT)
- done  output  1  one-cycle pulse after W[63] is accepted

## Operation
- States: IDLE, LOAD, EMIT, DONE.
- IDLE: outputs idle. beginSchedule=1 -> LOAD.
- LOAD: window[i] <= processedMsg[511-32i -: 32] for i=0..15; t <= 0; -> EMIT.
- EMIT: w_valid=1, w_out=window[0], w_index=t.
  - advance=0: hold everything (stall, unbounded).
  - advance=1, t<63: window shifts down one (window[i] <= window[i+1]), window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32; t <= t+1.
  - advance=1, t=63: -> DONE.
- DONE: done=1 for exactly one cycle, w_valid=0; -> IDLE.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). All additions 32-bit wrap, carries discarded.
- beginSchedule in LOAD, EMIT, or DONE is ignored; no queueing.
- advance outside EMIT is ignored.
- Window update for t=48..63 is computed but never emitted; harmless.

## Timing
- Reset (asynchronous, any state): state=IDLE, window all zero, t=0; w_out=0, w_index=0, w_valid=0, done=0. Reset mid-EMIT aborts the block; no done pulse.
- All outputs registered or decoded from registered state; no combinational path from advance or beginSchedule to outputs.
- beginSchedule high at edge k -> LOAD during cycle k+1 -> first valid word (W[0]) during cycle k+2.
- With advance held high: W[t] presented during cycle k+2+t; W[63] during k+65; done during k+66; IDLE at k+67. A new beginSchedule is accepted in cycle k+67 at the earliest.
- Each stall cycle delays all subsequent words and done by one cycle.
- Throughput: one word per cycle when not stalled.

## Structure
- Shared package sha256_pkg: state enum type (IDLE/LOAD/EMIT/DONE), NUM_WORDS, and the σ0/σ1 functions. The compression stage reuses Σ/σ definitions from this package.
- One combinational sub-module, sha256_sigma, computes the next window word (σ1(w14) + w9 + σ0(w1) + w0). The FSM, window, and counter stay in the top module.

## Test plan
- Reset check: assert n_rst low mid-simulation -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) with advance=1: W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405. All 64 words must match a software model. done must fall in cycle k+66.
- All-zero block: all 64 words are 0x00000000, with w_index stepping 0..63 consecutively.
- Random stalls: advance toggled pseudo-randomly -> word sequence identical to the unstalled run; w_out/w_index held stable while advance=0; done is one cycle after W[63] is accepted.
- Reset at t=30 during EMIT -> w_valid drops asynchronously and no done pulse occurs. A fresh beginSchedule then restarts at W[0].
- beginSchedule pulsed during EMIT and during DONE -> ignored; the current stream is unaffected and exactly one done pulse is produced.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: schedule FSM states, schedule length and the
// sigma/Sigma bit-mixing functions used by the schedule and compression stages.
package sha256_pkg;

  localparam int unsigned NUM_WORDS = 64;
  localparam int unsigned WinWords  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StEmit,
    StDone
  } sched_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

endpackage

// File: rtl/sha256_message_schedule_if.sv
// Block-in / word-out handshake between preprocessor, schedule and compression.
interface sha256_message_schedule_if;

  logic [511:0] processedMsg;
  logic         beginSchedule;
  logic         advance;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         w_valid;
  logic         done;

  modport master (
    output processedMsg, beginSchedule, advance,
    input  w_out, w_index, w_valid, done
  );

  modport slave (
    input  processedMsg, beginSchedule, advance,
    output w_out, w_index, w_valid, done
  );

endinterface

// File: rtl/sha256_sigma.sv
// Next message-schedule word from the 16-word sliding window.
module sha256_sigma
  import sha256_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] w_next_o
);

  assign w_next_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: captures one 512-bit block and streams W[0..63]
// through a valid/advance handshake using a 16-word sliding window.
module sha256_message_schedule
  import sha256_pkg::*;
(
  input  logic                       clk,
  input  logic                       n_rst,
  sha256_message_schedule_if.slave   bus
);

  localparam logic [5:0] LastIdx = 6'(NUM_WORDS - 1);

  sched_state_e                 state_q;
  logic [WinWords-1:0][31:0]    win_q;
  logic [5:0]                   t_q;
  logic                         valid_q;
  logic                         done_q;
  logic [31:0]                  w_next;

  sha256_sigma u_sigma (
    .w0_i     (win_q[0]),
    .w1_i     (win_q[1]),
    .w9_i     (win_q[9]),
    .w14_i    (win_q[14]),
    .w_next_o (w_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      win_q   <= '0;
      t_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.beginSchedule) state_q <= StLoad;
        end
        StLoad: begin
          for (int i = 0; i < int'(WinWords); i++) begin
            win_q[i] <= bus.processedMsg[511 - 32*i -: 32];
          end
          t_q     <= '0;
          valid_q <= 1'b1;
          state_q <= StEmit;
        end
        StEmit: begin
          if (bus.advance) begin
            if (t_q == LastIdx) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              for (int i = 0; i < int'(WinWords) - 1; i++) begin
                win_q[i] <= win_q[i+1];
              end
              win_q[WinWords-1] <= w_next;
              t_q               <= t_q + 6'd1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Gate the data outputs so they read zero whenever no word is on offer.
  assign bus.w_out   = valid_q ? win_q[0] : 32'd0;
  assign bus.w_index = valid_q ? t_q : 6'd0;
  assign bus.w_valid = valid_q;
  assign bus.done    = done_q;

endmodule
